i2c_master_ctrl: RTL and testbench

- Synthesizable I2C master that drives the bus upstream of the I2C slave `top`, replacing the behavioural bus tasks for on-chip loopback and system use.
- Runs fixed-format transactions: 7-bit device address, 16-bit register address, then a 32-bit data write or read.
- Open-drain style outputs. The board/top level ties SCL/SDA with pull-ups, e.g. `SDA_bus = sda_oe ? 1'b0 : 1'bz`.

---
 rtl/i2c_master_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: fixed-format I2C master (7-bit device, 16-bit register, 32-bit data).
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching on scl_in.
//
// state   | meaning
// IDLE    | wait for start, capture command, clear ack_err
// START   | SDA/SCL high 1 quarter, SDA low 2 quarters, then SCL low
// TX_BYTE | shift out 8 bits MSB first
// RX_ACK  | release SDA for one bit, sampled 1 = NACK
// RESTART | SDA released, SCL released, SDA low while SCL high (4 quarters)
// RX_BYTE | shift in 8 bits MSB first
// TX_ACK  | master ACK after read bytes 0-2, NACK after byte 3
// STOP    | SDA low/SCL low, SCL released, SDA released (3 quarters)
// DONE    | one-cycle done pulse, then IDLE
module i2c_master_ctrl #(
  parameter int         CLK_DIV   = 17,
  parameter logic [6:0] SLAVE_ADD = 7'h50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [15:0] reg_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in,
  input  logic        scl_in
);

  localparam int DIV_W = (CLK_DIV < 3) ? 1 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_ACK, STOP, DONE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [1:0]       qtr;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic [1:0]       rx_idx;
  logic             rw_q;
  logic [15:0]      reg_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rx_sh;
  logic             ack_bit;
  logic             hold;
  logic             tick;
  logic [7:0]       cur_byte;
  logic [7:0]       nxt_byte;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    frame_byte = {SLAVE_ADD, 1'b0};
      3'd1:    frame_byte = reg_q[15:8];
      3'd2:    frame_byte = reg_q[7:0];
      3'd3:    frame_byte = rw_q ? {SLAVE_ADD, 1'b1} : wdata_q[31:24];
      3'd4:    frame_byte = wdata_q[23:16];
      3'd5:    frame_byte = wdata_q[15:8];
      3'd6:    frame_byte = wdata_q[7:0];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    cur_byte = frame_byte(byte_idx);
    nxt_byte = frame_byte(byte_idx + 3'd1);
  end

`ifdef I2C_CLK_STRETCH_EN
  // Freeze the divider in Q2 of a data bit while a slave holds SCL low.
  logic bit_state;
  assign bit_state = (state == TX_BYTE) || (state == RX_ACK) ||
                     (state == RX_BYTE) || (state == TX_ACK);
  assign hold = bit_state && (qtr == 2'd2) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  assign tick = (state != IDLE) && (state != DONE) && (div == '0) && !hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      qtr      <= 2'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      rx_idx   <= 2'd0;
      rw_q     <= 1'b0;
      reg_q    <= 16'h0;
      wdata_q  <= 32'h0;
      rx_sh    <= 32'h0;
      ack_bit  <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rdata    <= 32'h0;
    end else begin
      done <= 1'b0;
      if (state == IDLE || state == DONE) div <= '0;
      else if (hold || div == '0)         div <= DIV_LOAD;
      else                                div <= div - DIV_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            rw_q     <= rw;
            reg_q    <= reg_addr;
            wdata_q  <= wdata;
            ack_err  <= 1'b0;
            busy     <= 1'b1;
            qtr      <= 2'd0;
            byte_idx <= 3'd0;
            rx_idx   <= 2'd0;
            rx_sh    <= 32'h0;
            div      <= DIV_LOAD;
            state    <= START;
          end
        end

        START: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd0) sda_oe <= 1'b1;
            else if (qtr == 2'd2) begin
              state   <= TX_BYTE;
              qtr     <= 2'd0;
              bit_idx <= 3'd7;
              scl_oe  <= 1'b1;
              sda_oe  <= ~cur_byte[7];
            end
          end
        end

        TX_BYTE, RX_ACK, RX_BYTE, TX_ACK: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd1: scl_oe <= 1'b0;
              2'd2: begin
                ack_bit <= sda_in;
                if (state == RX_BYTE) rx_sh <= {rx_sh[30:0], sda_in};
              end
              2'd3: begin
                // End of bit: SCL goes low and SDA takes the next bit's level.
                scl_oe <= 1'b1;
                case (state)
                  TX_BYTE: begin
                    if (bit_idx == 3'd0) begin
                      state  <= RX_ACK;
                      sda_oe <= 1'b0;
                    end else begin
                      bit_idx <= bit_idx - 3'd1;
                      sda_oe  <= ~cur_byte[bit_idx - 3'd1];
                    end
                  end
                  RX_ACK: begin
                    if (ack_bit) begin
                      ack_err <= 1'b1;
                      state   <= STOP;
                      sda_oe  <= 1'b1;
                    end else if (rw_q && byte_idx == 3'd2) begin
                      state    <= RESTART;
                      byte_idx <= 3'd3;
                      sda_oe   <= 1'b0;
                    end else if (rw_q && byte_idx == 3'd3) begin
                      state   <= RX_BYTE;
                      bit_idx <= 3'd7;
                      sda_oe  <= 1'b0;
                    end else if (byte_idx == 3'd6) begin
                      state  <= STOP;
                      sda_oe <= 1'b1;
                    end else begin
                      state    <= TX_BYTE;
                      byte_idx <= byte_idx + 3'd1;
                      bit_idx  <= 3'd7;
                      sda_oe   <= ~nxt_byte[7];
                    end
                  end
                  RX_BYTE: begin
                    if (bit_idx == 3'd0) begin
                      state  <= TX_ACK;
                      sda_oe <= (rx_idx != 2'd3);
                    end else begin
                      bit_idx <= bit_idx - 3'd1;
                      sda_oe  <= 1'b0;
                    end
                  end
                  default: begin
                    if (rx_idx == 2'd3) begin
                      state  <= STOP;
                      sda_oe <= 1'b1;
                    end else begin
                      state   <= RX_BYTE;
                      rx_idx  <= rx_idx + 2'd1;
                      bit_idx <= 3'd7;
                      sda_oe  <= 1'b0;
                    end
                  end
                endcase
              end
              default: ;
            endcase
          end
        end

        RESTART: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: scl_oe <= 1'b0;
              2'd1: sda_oe <= 1'b1;
              2'd3: begin
                state   <= TX_BYTE;
                bit_idx <= 3'd7;
                scl_oe  <= 1'b1;
                sda_oe  <= ~cur_byte[7];
              end
              default: ;
            endcase
          end
        end

        STOP: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: scl_oe <= 1'b0;
              2'd1: sda_oe <= 1'b0;
              2'd2: begin
                state <= DONE;
                qtr   <= 2'd0;
                done  <= 1'b1;
                if (rw_q && !ack_err) rdata <= rx_sh;
              end
              default: ;
            endcase
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural I2C slave holding a 16-byte memory.
// Stretch scenario compiles in only with I2C_CLK_STRETCH_EN.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;
  localparam int         CLK_DIV = 4;
  localparam logic [6:0] DEV     = 7'h50;

  logic        clk = 1'b0;
  logic        rst, start, rw;
  logic [15:0] reg_addr;
  logic [31:0] wdata, rdata;
  logic        busy, done, ack_err, scl_oe, sda_oe, sda_in, scl_in;

  logic s_sda    = 1'b0;
  logic scl_hold = 1'b0;
  wire  scl_line = !(scl_oe || scl_hold);
  wire  sda_line = !(sda_oe || s_sda);
  assign sda_in = sda_line;
  assign scl_in = scl_line;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .SLAVE_ADD(DEV)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .reg_addr(reg_addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in), .scl_in(scl_in)
  );

  // Slave model
  logic [6:0] slave_dev = DEV;
  logic [7:0] mem [16];
  logic [7:0] bus_q [$];
  logic       mack_q [$];
  int         start_cnt = 0, stop_cnt = 0;
  int         phase = 0, bc = 0, byte_num = 0;
  logic [7:0] sh = 8'h0, tx = 8'h0;
  logic [3:0] ptr = 4'h0;
  logic       rmode = 1'b0, m_ack = 1'b0, p_scl = 1'b1, p_sda = 1'b1;
  int         hold_cnt = 0, hi_len = 0;
  logic       stretch_arm = 1'b0, meas = 1'b0;

  always @(posedge clk) begin
    if (meas) begin
      if (scl_line) hi_len++;
      else if (hi_len > 0) meas = 1'b0;
    end
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) begin scl_hold <= 1'b0; meas = 1'b1; hi_len = 0; end
    end
    if (p_scl && scl_line && p_sda && !sda_line) begin
      start_cnt++; phase = 1; bc = 0; byte_num = 0; s_sda <= 1'b0;
    end else if (p_scl && scl_line && !p_sda && sda_line) begin
      stop_cnt++; phase = 0; s_sda <= 1'b0;
    end else if (!p_scl && scl_line) begin
      if (phase == 1) begin
        sh = {sh[6:0], sda_line}; bc++;
        if (bc == 8) bus_q.push_back(sh);
      end else if (phase == 3) bc++;
      else if (phase == 4) begin m_ack = sda_line; mack_q.push_back(m_ack); end
    end else if (p_scl && !scl_line) begin
      if (phase == 1 && bc == 8) begin
        if (byte_num == 0) begin
          rmode = sh[0];
          if (sh[7:1] == slave_dev) begin phase = 2; s_sda <= 1'b1; end
          else phase = 0;
        end else begin
          if (byte_num == 2) ptr = sh[3:0];
          else if (byte_num >= 3) begin mem[ptr] = sh; ptr++; end
          phase = 2; s_sda <= 1'b1;
        end
        byte_num++;
      end else if (phase == 2) begin
        if (stretch_arm) begin hold_cnt = 40; stretch_arm = 1'b0; scl_hold <= 1'b1; end
        bc = 0;
        if (rmode) begin tx = mem[ptr]; ptr++; phase = 3; s_sda <= !tx[7]; end
        else begin phase = 1; s_sda <= 1'b0; end
      end else if (phase == 3) begin
        if (bc == 8) begin phase = 4; s_sda <= 1'b0; end
        else s_sda <= !tx[3'(7 - bc)];
      end else if (phase == 4) begin
        if (!m_ack) begin tx = mem[ptr]; ptr++; bc = 0; phase = 3; s_sda <= !tx[7]; end
        else begin phase = 0; s_sda <= 1'b0; end
      end
    end
    p_scl = scl_line;
    p_sda = sda_line;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'h0, obs}, {31'h0, exp});
  endtask

  task automatic chk_bytes(input string tag, input logic [55:0] exp, input int n);
    chk({tag, " count"}, 32'(bus_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      chk(tag, {24'h0, (i < bus_q.size()) ? bus_q[i] : 8'hxx}, {24'h0, exp[8*(n-1-i) +: 8]});
  endtask

  task automatic cmd(input logic r, input logic [15:0] a, input logic [31:0] d);
    bus_q.delete();
    mack_q.delete();
    @(negedge clk);
    start = 1'b1; rw = r; reg_addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20000) begin @(negedge clk); n++; end
    chk1({tag, " done"}, done, 1'b1);
    @(negedge clk);
    chk1({tag, " done width"}, done, 1'b0);
    chk1({tag, " busy after"}, busy, 1'b0);
  endtask

  initial begin
    int n, s0, p0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst = 1'b1; start = 1'b0; rw = 1'b0; reg_addr = 16'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk1("rst scl_oe", scl_oe, 1'b0);
    chk1("rst sda_oe", sda_oe, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst ack_err", ack_err, 1'b0);
    chk("rst rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Write 01020304 to register 0
    s0 = stop_cnt;
    cmd(1'b0, 16'h0000, 32'h01020304);
    chk1("wr busy", busy, 1'b1);
    wait_done("wr");
    chk_bytes("wr bytes", 56'hA0_00_00_01_02_03_04, 7);
    chk1("wr ack_err", ack_err, 1'b0);
    chk("wr stop", 32'(stop_cnt - s0), 32'd1);

    // Read it back
    cmd(1'b1, 16'h0000, 32'h0);
    wait_done("rd");
    chk_bytes("rd bytes", 56'h00_00_00_A0_00_00_A1, 4);
    chk("rd master acks", 32'(mack_q.size()), 32'd4);
    chk("rd ack pattern", {28'h0, mack_q[0], mack_q[1], mack_q[2], mack_q[3]}, 32'h1);
    chk("rd rdata", rdata, 32'h01020304);
    chk1("rd ack_err", ack_err, 1'b0);

    // No device answers at the DUT's address
    slave_dev = 7'h52;
    s0 = stop_cnt;
    cmd(1'b0, 16'h0000, 32'hDEADBEEF);
    wait_done("nack");
    chk1("nack ack_err", ack_err, 1'b1);
    chk_bytes("nack bytes", 56'hA0, 1);
    chk("nack stop", 32'(stop_cnt - s0), 32'd1);
    chk("nack rdata", rdata, 32'h01020304);
    repeat (10) @(negedge clk);
    chk1("nack ack_err held", ack_err, 1'b1);
    slave_dev = DEV;

    // Second start while busy is ignored
    s0 = start_cnt;
    cmd(1'b0, 16'h0008, 32'h11223344);
    chk1("busy clears ack_err", ack_err, 1'b0);
    repeat (20) @(negedge clk);
    chk1("busy mid", busy, 1'b1);
    start = 1'b1; rw = 1'b1; reg_addr = 16'h0000; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy");
    chk_bytes("busy bytes", 56'hA0_00_08_11_22_33_44, 7);
    repeat (100) @(negedge clk);
    chk("busy single txn", 32'(start_cnt - s0), 32'd1);
    chk1("busy idle", busy, 1'b0);

    // Reset in the third data byte, then a clean write and readback
    cmd(1'b0, 16'h000C, 32'h55667788);
    n = 0;
    while (bus_q.size() < 5 && n < 5000) begin @(negedge clk); n++; end
    chk1("mid reach", bus_q.size() >= 5, 1'b1);
    repeat (40) @(negedge clk);
    chk1("mid busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("mid scl_oe", scl_oe, 1'b0);
    chk1("mid sda_oe", sda_oe, 1'b0);
    chk1("mid busy cleared", busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    cmd(1'b0, 16'h0004, 32'hA5A55A5A);
    wait_done("post");
    chk_bytes("post bytes", 56'hA0_00_04_A5_A5_5A_5A, 7);
    chk1("post ack_err", ack_err, 1'b0);
    cmd(1'b1, 16'h0004, 32'h0);
    wait_done("post rd");
    chk("post rdata", rdata, 32'hA5A55A5A);

`ifdef I2C_CLK_STRETCH_EN
    // Slave holds SCL for 40 clk after the first ACK bit
    p0 = 0;
    stretch_arm = 1'b1;
    cmd(1'b0, 16'h0000, 32'hCAFEF00D);
    wait_done("str");
    chk("str high phase", 32'(hi_len), 32'(2 * CLK_DIV));
    chk_bytes("str bytes", 56'hA0_00_00_CA_FE_F0_0D, 7);
    cmd(1'b1, 16'h0000, 32'h0);
    wait_done("str rd");
    chk("str rdata", rdata, 32'hCAFEF00D + 32'(p0));
`else
    p0 = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
